// File: rtl/qsys_basic_rgb_fader_if.sv
// Avalon-MM control slave and Avalon-ST colour source of the RGB fader.
// Signal names follow the Qsys/Platform Designer port naming of the block.
interface qsys_basic_rgb_fader_if;
  logic [1:0]  avs_CTRL_address;
  logic [31:0] avs_CTRL_writedata;
  logic [31:0] avs_CTRL_readdata;
  logic [3:0]  avs_CTRL_byteenable;
  logic        avs_CTRL_write;
  logic        avs_CTRL_read;
  logic        avs_CTRL_waitrequest;
  logic [23:0] aso_LEDS_data;
  logic        aso_LEDS_valid;
  logic        aso_LEDS_ready;

  modport slave (
    input  avs_CTRL_address, avs_CTRL_writedata, avs_CTRL_byteenable,
           avs_CTRL_write, avs_CTRL_read, aso_LEDS_ready,
    output avs_CTRL_readdata, avs_CTRL_waitrequest, aso_LEDS_data, aso_LEDS_valid
  );

  modport master (
    output avs_CTRL_address, avs_CTRL_writedata, avs_CTRL_byteenable,
           avs_CTRL_write, avs_CTRL_read, aso_LEDS_ready,
    input  avs_CTRL_readdata, avs_CTRL_waitrequest, aso_LEDS_data, aso_LEDS_valid
  );
endinterface

// File: rtl/qsys_basic_rgb_fader.sv
// RGB fader: ramps a 24-bit colour from COLOR_A to COLOR_B, one stream beat per step.
// Define RGB_FADER_IRQ_EN to add the ins_IRQ_irq completion interrupt and W1C on DONE.
module qsys_basic_rgb_fader #(
  parameter int PRESCALE_W = 16,
  parameter int STEP_SIZE  = 1
) (
  input  logic csi_MCLK_clk,
  input  logic rsi_MRST_reset_n,
`ifdef RGB_FADER_IRQ_EN
  output logic ins_IRQ_irq,
`endif
  qsys_basic_rgb_fader_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT} state_t;

  localparam logic [7:0] STEP8 = 8'(STEP_SIZE);

  state_t                state_q, state_d;
  logic                  en_q, en_d, loop_q, loop_d, done_q, done_d;
  logic                  tgt_b_q, tgt_b_d;
  logic [23:0]           col_a_q, col_a_d, col_b_q, col_b_d;
  logic [23:0]           cur_q, cur_d, tgt_q, tgt_d, cur_step;
  logic [PRESCALE_W-1:0] div_q, div_d, cnt_q, cnt_d, div_eff;
  logic [31:0]           m_a, m_b, m_div;
  logic                  accept;
  logic                  unused_rd;

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  // Move one channel toward its target, landing exactly on it rather than overshooting.
  function automatic logic [7:0] step_ch(input logic [7:0] c, input logic [7:0] t);
    logic [7:0] d;
    if (c < t) begin
      d = t - c;
      return (d > STEP8) ? c + STEP8 : t;
    end
    d = c - t;
    return (d > STEP8) ? c - STEP8 : t;
  endfunction

  assign cur_step = {step_ch(cur_q[23:16], tgt_q[23:16]),
                     step_ch(cur_q[15:8],  tgt_q[15:8]),
                     step_ch(cur_q[7:0],   tgt_q[7:0])};
  assign div_eff  = (div_q == '0) ? PRESCALE_W'(1) : div_q;
  assign accept   = (state_q == S_EMIT) && bus.aso_LEDS_ready;
  assign unused_rd = bus.avs_CTRL_read;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    loop_d  = loop_q;
    done_d  = done_q;
    tgt_b_d = tgt_b_q;
    col_a_d = col_a_q;
    col_b_d = col_b_q;
    div_d   = div_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    m_a     = be_merge(32'(col_a_q), bus.avs_CTRL_writedata, bus.avs_CTRL_byteenable);
    m_b     = be_merge(32'(col_b_q), bus.avs_CTRL_writedata, bus.avs_CTRL_byteenable);
    m_div   = be_merge(32'(div_q),   bus.avs_CTRL_writedata, bus.avs_CTRL_byteenable);

    if (bus.avs_CTRL_write) begin
      case (bus.avs_CTRL_address)
        2'd0: begin
          if (bus.avs_CTRL_byteenable[0]) begin
            loop_d = bus.avs_CTRL_writedata[1];
            if (state_q == S_IDLE) begin
              en_d = bus.avs_CTRL_writedata[0];
              if (bus.avs_CTRL_writedata[0] && !en_q) begin
                cur_d   = col_a_q;
                tgt_d   = col_b_q;
                tgt_b_d = 1'b1;
                done_d  = 1'b0;
              end
            end else begin
              // While running, ENABLE can only be dropped, never re-armed.
              en_d = en_q & bus.avs_CTRL_writedata[0];
            end
          end
`ifdef RGB_FADER_IRQ_EN
          if (bus.avs_CTRL_byteenable[1] && bus.avs_CTRL_writedata[8]) done_d = 1'b0;
`endif
        end
        2'd1: col_a_d = m_a[23:0];
        2'd2: col_b_d = m_b[23:0];
        2'd3: div_d   = m_div[PRESCALE_W-1:0];
      endcase
    end

    // FSM updates come last so a completion wins over a same-cycle DONE clear.
    case (state_q)
      S_IDLE: if (en_q) state_d = S_EMIT;
      S_EMIT: begin
        if (accept) begin
          if (!en_q) begin
            state_d = S_IDLE;
          end else if (cur_q == tgt_q && !loop_q) begin
            done_d  = 1'b1;
            en_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            if (cur_q == tgt_q) begin
              tgt_b_d = !tgt_b_q;
              tgt_d   = tgt_b_q ? col_a_q : col_b_q;
            end
            cnt_d   = div_eff - PRESCALE_W'(1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          cur_d   = cur_step;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q - PRESCALE_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      tgt_b_q <= 1'b0;
      col_a_q <= '0;
      col_b_q <= '0;
      div_q   <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      tgt_b_q <= tgt_b_d;
      col_a_q <= col_a_d;
      col_b_q <= col_b_d;
      div_q   <= div_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RGB_FADER_IRQ_EN
  logic irq_q;
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) irq_q <= 1'b0;
    else                   irq_q <= done_q;
  end
  assign ins_IRQ_irq = irq_q;
`endif

  always_comb begin
    bus.avs_CTRL_readdata = '0;
    case (bus.avs_CTRL_address)
      2'd0: bus.avs_CTRL_readdata = {(state_q != S_IDLE), 22'd0, done_q, 6'd0, loop_q, en_q};
      2'd1: bus.avs_CTRL_readdata = 32'(col_a_q);
      2'd2: bus.avs_CTRL_readdata = 32'(col_b_q);
      2'd3: bus.avs_CTRL_readdata = 32'(div_q);
    endcase
  end

  assign bus.avs_CTRL_waitrequest = 1'b0;
  assign bus.aso_LEDS_data        = cur_q;
  assign bus.aso_LEDS_valid       = (state_q == S_EMIT);
endmodule

// File: tb/tb_qsys_basic_rgb_fader.sv
// Directed bench for qsys_basic_rgb_fader: table of fade vectors plus hand sequences.
// Instance u0 uses STEP_SIZE=1, instance u1 uses STEP_SIZE=16.
module tb_qsys_basic_rgb_fader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qsys_basic_rgb_fader_if b0();
  qsys_basic_rgb_fader_if b1();
`ifdef RGB_FADER_IRQ_EN
  logic irq0, irq1;
`endif

  qsys_basic_rgb_fader #(.PRESCALE_W(16), .STEP_SIZE(1)) u0 (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
`ifdef RGB_FADER_IRQ_EN
    .ins_IRQ_irq(irq0),
`endif
    .bus(b0));

  qsys_basic_rgb_fader #(.PRESCALE_W(16), .STEP_SIZE(16)) u1 (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
`ifdef RGB_FADER_IRQ_EN
    .ins_IRQ_irq(irq1),
`endif
    .bus(b1));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          sel;
    logic [23:0] a, b;
    logic [31:0] div;
    int          nb;
    int          gap;
    logic [23:0] exp [4];
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    if (sel) begin
      b1.avs_CTRL_address = a; b1.avs_CTRL_writedata = d;
      b1.avs_CTRL_byteenable = be; b1.avs_CTRL_write = 1'b1;
    end else begin
      b0.avs_CTRL_address = a; b0.avs_CTRL_writedata = d;
      b0.avs_CTRL_byteenable = be; b0.avs_CTRL_write = 1'b1;
    end
    @(negedge clk);
    b0.avs_CTRL_write = 1'b0;
    b1.avs_CTRL_write = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, output logic [31:0] d);
    if (sel) begin
      b1.avs_CTRL_address = a; #1 d = b1.avs_CTRL_readdata;
    end else begin
      b0.avs_CTRL_address = a; #1 d = b0.avs_CTRL_readdata;
    end
  endtask

  // Returns the beat seen at the next negedge with valid high and how many negedges it took.
  task automatic wait_beat(input bit sel, output logic [23:0] d, output int n);
    n = 0;
    d = '0;
    repeat (60) begin
      @(negedge clk);
      n++;
      if (sel ? b1.aso_LEDS_valid : b0.aso_LEDS_valid) begin
        d = sel ? b1.aso_LEDS_data : b0.aso_LEDS_data;
        return;
      end
    end
    n = -1;
  endtask

  task automatic count_valid(input bit sel, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (sel ? b1.aso_LEDS_valid : b0.aso_LEDS_valid) cnt++;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [23:0] d;
    int          n, extra;
    logic [7:0]  blue [6];

    vt[0] = '{sel:1'b0, a:24'h000000, b:24'h030201, div:32'd4, nb:4, gap:5,
              exp:'{24'h000000, 24'h010101, 24'h020201, 24'h030201}};
    vt[1] = '{sel:1'b0, a:24'h123456, b:24'h123456, div:32'd2, nb:1, gap:3,
              exp:'{24'h123456, 24'h0, 24'h0, 24'h0}};
    vt[2] = '{sel:1'b0, a:24'h050505, b:24'h020304, div:32'd1, nb:4, gap:2,
              exp:'{24'h050505, 24'h040404, 24'h030304, 24'h020304}};
    vt[3] = '{sel:1'b0, a:24'h000000, b:24'h000002, div:32'd0, nb:3, gap:2,
              exp:'{24'h000000, 24'h000001, 24'h000002, 24'h0}};
    vt[4] = '{sel:1'b1, a:24'hF8F8F8, b:24'hFFFFFF, div:32'd1, nb:2, gap:2,
              exp:'{24'hF8F8F8, 24'hFFFFFF, 24'h0, 24'h0}};
    blue = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd1};

    b0.avs_CTRL_address = '0; b0.avs_CTRL_writedata = '0; b0.avs_CTRL_byteenable = '0;
    b0.avs_CTRL_write = 1'b0; b0.avs_CTRL_read = 1'b0; b0.aso_LEDS_ready = 1'b1;
    b1.avs_CTRL_address = '0; b1.avs_CTRL_writedata = '0; b1.avs_CTRL_byteenable = '0;
    b1.avs_CTRL_write = 1'b0; b1.avs_CTRL_read = 1'b0; b1.aso_LEDS_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(b0.aso_LEDS_valid), 32'd0);
    chk("rst data", 32'(b0.aso_LEDS_data), 32'd0);
    chk("rst valid u1", 32'(b1.aso_LEDS_valid), 32'd0);
    chk("rst waitreq", 32'({b0.avs_CTRL_waitrequest, b1.avs_CTRL_waitrequest}), 32'd0);
`ifdef RGB_FADER_IRQ_EN
    chk("rst irq", 32'({irq0, irq1}), 32'd0);
`endif
    for (int a = 0; a < 4; a++) begin
      rd(1'b0, 2'(a), r);
      chk($sformatf("rst readdata[%0d]", a), r, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Byte-lane writes and unused bits
    wr(1'b0, 2'd1, 32'hFFAABBCC, 4'b0101);
    rd(1'b0, 2'd1, r);
    chk("be COLOR_A", r, 32'h00AA00CC);
    wr(1'b0, 2'd3, 32'hFFFFFFFF, 4'hF);
    rd(1'b0, 2'd3, r);
    chk("STEP_DIV width", r, 32'h0000FFFF);

    // Table-driven fades with ready held high
    for (int i = 0; i < 5; i++) begin
      wr(vt[i].sel, 2'd1, 32'(vt[i].a), 4'hF);
      wr(vt[i].sel, 2'd2, 32'(vt[i].b), 4'hF);
      wr(vt[i].sel, 2'd3, vt[i].div, 4'hF);
      wr(vt[i].sel, 2'd0, 32'h1, 4'h1);
      for (int k = 0; k < vt[i].nb; k++) begin
        wait_beat(vt[i].sel, d, n);
        chk($sformatf("v%0d beat%0d data", i, k), 32'(d), 32'(vt[i].exp[k]));
        chk($sformatf("v%0d beat%0d spacing", i, k), n, (k == 0) ? 1 : vt[i].gap);
      end
      count_valid(vt[i].sel, 12, extra);
      chk($sformatf("v%0d extra beats", i), extra, 0);
      rd(vt[i].sel, 2'd0, r);
      chk($sformatf("v%0d CTRL done", i), r, 32'h00000100);
    end

    // Back-pressure on the second beat
    wr(1'b0, 2'd1, 32'h000000, 4'hF);
    wr(1'b0, 2'd2, 32'h030201, 4'hF);
    wr(1'b0, 2'd3, 32'd4, 4'hF);
    wr(1'b0, 2'd0, 32'h1, 4'h1);
    wait_beat(1'b0, d, n);
    chk("bp beat0", 32'(d), 32'h000000);
    @(negedge clk);
    b0.aso_LEDS_ready = 1'b0;
    wait_beat(1'b0, d, n);
    chk("bp beat1", 32'(d), 32'h010101);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(b0.aso_LEDS_valid && b0.aso_LEDS_data == 24'h010101)) extra++;
    end
    chk("bp hold cycles bad", extra, 0);
    b0.aso_LEDS_ready = 1'b1;
    wait_beat(1'b0, d, n);
    chk("bp beat2", 32'(d), 32'h020201);
    chk("bp step after accept", n, 5);
    wait_beat(1'b0, d, n);
    chk("bp beat3", 32'(d), 32'h030201);
    count_valid(1'b0, 8, extra);
    rd(1'b0, 2'd0, r);
    chk("bp CTRL done", r, 32'h00000100);

    // Ping-pong, then disable during WAIT
    wr(1'b0, 2'd1, 32'h000000, 4'hF);
    wr(1'b0, 2'd2, 32'h000002, 4'hF);
    wr(1'b0, 2'd3, 32'd4, 4'hF);
    wr(1'b0, 2'd0, 32'h3, 4'h1);
    for (int k = 0; k < 6; k++) begin
      wait_beat(1'b0, d, n);
      chk($sformatf("loop beat%0d", k), 32'(d), 32'(blue[k]));
    end
    wr(1'b0, 2'd0, 32'h2, 4'h1);
    count_valid(1'b0, 15, extra);
    chk("loop beats after disable", extra, 0);
    rd(1'b0, 2'd0, r);
    chk("loop CTRL after disable", r, 32'h00000002);
    wr(1'b0, 2'd0, 32'h0, 4'h1);

    // Completion flag, interrupt and DONE write behaviour
    wr(1'b0, 2'd1, 32'h111111, 4'hF);
    wr(1'b0, 2'd2, 32'h111111, 4'hF);
    wr(1'b0, 2'd3, 32'd1, 4'hF);
    wr(1'b0, 2'd0, 32'h1, 4'h1);
    wait_beat(1'b0, d, n);
    chk("done beat", 32'(d), 32'h111111);
    @(negedge clk);
    rd(1'b0, 2'd0, r);
    chk("done set", r, 32'h00000100);
`ifdef RGB_FADER_IRQ_EN
    chk("irq not yet", 32'(irq0), 32'd0);
    @(negedge clk);
    chk("irq asserted", 32'(irq0), 32'd1);
`endif
    wr(1'b0, 2'd0, 32'h100, 4'b0010);
    rd(1'b0, 2'd0, r);
`ifdef RGB_FADER_IRQ_EN
    chk("W1C clears DONE", r, 32'h00000000);
    chk("irq still high", 32'(irq0), 32'd1);
    @(negedge clk);
    chk("irq cleared", 32'(irq0), 32'd0);
`else
    chk("DONE ignores writes", r, 32'h00000100);
`endif

    // Reset while a beat is stalled
    b0.aso_LEDS_ready = 1'b0;
    wr(1'b0, 2'd1, 32'h0A0B0C, 4'hF);
    wr(1'b0, 2'd2, 32'h0A0B0C, 4'hF);
    wr(1'b0, 2'd0, 32'h1, 4'h1);
    wait_beat(1'b0, d, n);
    chk("pre-reset valid seen", n, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-beat reset valid", 32'(b0.aso_LEDS_valid), 32'd0);
    chk("mid-beat reset data", 32'(b0.aso_LEDS_data), 32'd0);
`ifdef RGB_FADER_IRQ_EN
    chk("mid-beat reset irq", 32'(irq0), 32'd0);
`endif
    rd(1'b0, 2'd0, r);
    chk("mid-beat reset CTRL", r, 32'd0);
    rd(1'b0, 2'd1, r);
    chk("mid-beat reset COLOR_A", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b0.aso_LEDS_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
